// File: rtl/tmr_pkg.sv
// -----------------------------------------------------------------------------
// tmr_pkg
// Shared definitions for the triple-redundant register file:
//   NUM_COPIES    - number of redundant copies held for every register
//   scrub_state_e - background scrubber FSM states
//   maj3          - single-bit majority vote, applied bitwise to whole words
//                   by tmr_vote3 so that any XLEN can be voted
// -----------------------------------------------------------------------------
package tmr_pkg;

   localparam int NUM_COPIES = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      REPAIR = 2'd2
   } scrub_state_e;

   // Bitwise majority: a word vote is this function applied to every bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (b & c) | (a & c);
   endfunction

endpackage

// File: rtl/tmr_vote3.sv
// -----------------------------------------------------------------------------
// tmr_vote3
// Combinational bitwise 2-of-3 majority voter for one XLEN-bit word.
// Ports:
//   a_i, b_i, c_i : the three redundant copies
//   y_o           : voted word, y = (a&b)|(b&c)|(a&c)
// -----------------------------------------------------------------------------
module tmr_vote3
   import tmr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [XLEN-1:0] c_i,
   output logic [XLEN-1:0] y_o
);

   always_comb begin
      y_o = '0;
      for (int i = 0; i < XLEN; i++) begin
         y_o[i] = maj3(a_i[i], b_i[i], c_i[i]);
      end
   end

endmodule

// File: rtl/tmr_regfile_scrub.sv
// -----------------------------------------------------------------------------
// tmr_regfile_scrub
// Triple-redundant register file with voted reads, a background scrubber that
// rewrites disagreeing entries with their voted value, and a per-copy fault
// injection port.
// Ports:
//   clk, rst_in                 : clock, asynchronous active-low reset
//   we, waddr, wdata            : functional write port (all three copies)
//   raddr1/rdata1, raddr2/rdata2: combinational voted read ports
//   inj_en, inj_copy, inj_addr,
//   inj_mask                    : XOR-flip one copy of one register
//   scrub_en                    : enables the background scrubber
//   scrub_busy                  : scrubber is in CHECK or REPAIR
//   corr_count                  : saturating count of completed repairs
//   uncorr_flag                 : sticky, a word had three pairwise-different copies
//   last_err_addr               : address of the most recent repair
// x0 and addresses >= NREGS read as zero and ignore writes and injections.
// -----------------------------------------------------------------------------
module tmr_regfile_scrub
   import tmr_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int AW        = 5,
   parameter int SCRUB_GAP = 16,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [XLEN-1:0]  wdata,
   input  logic [AW-1:0]    raddr1,
   input  logic [AW-1:0]    raddr2,
   output logic [XLEN-1:0]  rdata1,
   output logic [XLEN-1:0]  rdata2,
   input  logic             inj_en,
   input  logic [1:0]       inj_copy,
   input  logic [AW-1:0]    inj_addr,
   input  logic [XLEN-1:0]  inj_mask,
   input  logic             scrub_en,
   output logic             scrub_busy,
   output logic [CNT_W-1:0] corr_count,
   output logic             uncorr_flag,
   output logic [AW-1:0]    last_err_addr
);

   // Gap counter only has to reach SCRUB_GAP-1.
   localparam int GW = (SCRUB_GAP > 1) ? $clog2(SCRUB_GAP) : 1;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   // True for architecturally writable registers x1..x(NREGS-1).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && (int'(a) < NREGS);
   endfunction

   // Scrub pointer walks 1..NREGS-1 and wraps back to 1, skipping x0.
   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      if (int'(p) >= NREGS - 1) begin
         return AW'(1);
      end
      return p + AW'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0]  mem_q [NUM_COPIES][NREGS];
   logic [XLEN-1:0]  mem_d [NUM_COPIES][NREGS];

   scrub_state_e     state_q, state_d;
   logic [GW-1:0]    gap_q;
   logic [AW-1:0]    ptr_q;
   logic [XLEN-1:0]  voted_q;
   logic [CNT_W-1:0] corr_q;
   logic             uncorr_q;
   logic [AW-1:0]    last_err_q;

   // FSM-derived strobes
   logic             gap_hit;
   logic             mismatch;
   logic             all_diff;
   logic             wr_hit_ptr;
   logic             latch_vote;
   logic             repair_go;
   logic             ptr_adv;

   // ---------------------------------------------------------------------------
   // Read ports: out-of-range addresses are steered to x0 (always zero) so the
   // array is never indexed beyond NREGS.
   // ---------------------------------------------------------------------------
   logic [AW-1:0]   ra1_idx, ra2_idx;
   logic [XLEN-1:0] v1, v2, sv;
   logic [XLEN-1:0] sc0, sc1, sc2;

   assign ra1_idx = addr_ok(raddr1) ? raddr1 : '0;
   assign ra2_idx = addr_ok(raddr2) ? raddr2 : '0;

   tmr_vote3 #(.XLEN(XLEN)) u_vote_rd1 (
      .a_i (mem_q[0][ra1_idx]),
      .b_i (mem_q[1][ra1_idx]),
      .c_i (mem_q[2][ra1_idx]),
      .y_o (v1)
   );

   tmr_vote3 #(.XLEN(XLEN)) u_vote_rd2 (
      .a_i (mem_q[0][ra2_idx]),
      .b_i (mem_q[1][ra2_idx]),
      .c_i (mem_q[2][ra2_idx]),
      .y_o (v2)
   );

   assign rdata1 = addr_ok(raddr1) ? v1 : '0;
   assign rdata2 = addr_ok(raddr2) ? v2 : '0;

   // ---------------------------------------------------------------------------
   // Scrub compare path at the scrub pointer
   // ---------------------------------------------------------------------------
   assign sc0 = mem_q[0][ptr_q];
   assign sc1 = mem_q[1][ptr_q];
   assign sc2 = mem_q[2][ptr_q];

   tmr_vote3 #(.XLEN(XLEN)) u_vote_scrub (
      .a_i (sc0),
      .b_i (sc1),
      .c_i (sc2),
      .y_o (sv)
   );

   assign mismatch   = (sc0 != sc1) || (sc1 != sc2);
   assign all_diff   = (sc0 != sc1) && (sc1 != sc2) && (sc0 != sc2);
   assign gap_hit    = (int'(gap_q) == SCRUB_GAP - 1);
   assign wr_hit_ptr = we && addr_ok(waddr) && (waddr == ptr_q);

   // ---------------------------------------------------------------------------
   // Scrub FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Scrub FSM: next state. Once CHECK starts the check/repair runs to
   // completion regardless of scrub_en; IDLE is where scrub_en is honoured.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (scrub_en && gap_hit) state_d = CHECK;
         CHECK:   state_d = mismatch ? REPAIR : IDLE;
         REPAIR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Scrub FSM: outputs. A functional write to the pointer during REPAIR owns
   // the entry, so the repair write and its count are dropped.
   // ---------------------------------------------------------------------------
   always_comb begin
      scrub_busy = 1'b0;
      latch_vote = 1'b0;
      repair_go  = 1'b0;
      ptr_adv    = 1'b0;
      case (state_q)
         CHECK: begin
            scrub_busy = 1'b1;
            latch_vote = mismatch;
            ptr_adv    = !mismatch;
         end
         REPAIR: begin
            scrub_busy = 1'b1;
            repair_go  = !wr_hit_ptr;
            ptr_adv    = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Scrubber control registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         gap_q      <= '0;
         ptr_q      <= AW'(1);
         corr_q     <= '0;
         uncorr_q   <= 1'b0;
         last_err_q <= '0;
      end else begin
         if (state_q == IDLE && scrub_en) begin
            gap_q <= gap_hit ? '0 : gap_q + GW'(1);
         end
         if (ptr_adv) begin
            ptr_q <= ptr_next(ptr_q);
         end
         if (state_q == CHECK && all_diff) begin
            uncorr_q <= 1'b1;
         end
         if (repair_go) begin
            if (!(&corr_q)) begin
               corr_q <= corr_q + CNT_W'(1);
            end
            last_err_q <= ptr_q;
         end
      end
   end

   // Voted value captured in CHECK, consumed in REPAIR; needs no reset.
   always_ff @(posedge clk) begin
      if (latch_vote) begin
         voted_q <= sv;
      end
   end

   // ---------------------------------------------------------------------------
   // Array next state, in priority order: repair, functional write, then the
   // injection XOR on top of whichever of the two landed.
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_d = mem_q;
      for (int c = 0; c < NUM_COPIES; c++) begin
         if (repair_go) begin
            mem_d[c][ptr_q] = voted_q;
         end
         if (we && addr_ok(waddr)) begin
            mem_d[c][waddr] = wdata;
         end
         if (inj_en && (inj_copy == 2'(c)) && addr_ok(inj_addr)) begin
            mem_d[c][inj_addr] = mem_d[c][inj_addr] ^ inj_mask;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         for (int c = 0; c < NUM_COPIES; c++) begin
            for (int r = 0; r < NREGS; r++) begin
               mem_q[c][r] <= '0;
            end
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign corr_count    = corr_q;
   assign uncorr_flag   = uncorr_q;
   assign last_err_addr = last_err_q;

endmodule

// File: tb/tb_tmr_regfile_scrub.sv
// -----------------------------------------------------------------------------
// tb_tmr_regfile_scrub
// Directed bench for tmr_regfile_scrub (SCRUB_GAP=4). The stimulus process
// pushes hand-computed expectations into a queue; a monitor on the falling
// clock edge pops each one and compares it against the selected DUT output.
// Individual copies are observed through the voted port by temporarily
// flipping one copy with an all-ones mask and reading the vote of the other two.
// -----------------------------------------------------------------------------
module tb_tmr_regfile_scrub;

   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int CNT_W = 16;

   localparam int SEL_RD1  = 0;
   localparam int SEL_RD2  = 1;
   localparam int SEL_CORR = 2;
   localparam int SEL_UNC  = 3;
   localparam int SEL_LAST = 4;
   localparam int SEL_BUSY = 5;

   logic             clk;
   logic             rst_in;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [XLEN-1:0]  wdata;
   logic [AW-1:0]    raddr1;
   logic [AW-1:0]    raddr2;
   logic [XLEN-1:0]  rdata1;
   logic [XLEN-1:0]  rdata2;
   logic             inj_en;
   logic [1:0]       inj_copy;
   logic [AW-1:0]    inj_addr;
   logic [XLEN-1:0]  inj_mask;
   logic             scrub_en;
   logic             scrub_busy;
   logic [CNT_W-1:0] corr_count;
   logic             uncorr_flag;
   logic [AW-1:0]    last_err_addr;

   tmr_regfile_scrub #(
      .XLEN(XLEN), .NREGS(32), .AW(AW), .SCRUB_GAP(4), .CNT_W(CNT_W)
   ) dut (
      .clk           (clk),
      .rst_in        (rst_in),
      .we            (we),
      .waddr         (waddr),
      .wdata         (wdata),
      .raddr1        (raddr1),
      .raddr2        (raddr2),
      .rdata1        (rdata1),
      .rdata2        (rdata2),
      .inj_en        (inj_en),
      .inj_copy      (inj_copy),
      .inj_addr      (inj_addr),
      .inj_mask      (inj_mask),
      .scrub_en      (scrub_en),
      .scrub_busy    (scrub_busy),
      .corr_count    (corr_count),
      .uncorr_flag   (uncorr_flag),
      .last_err_addr (last_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad   = 0;
   exp_t        mon_e;
   logic [31:0] mon_act;

   // Monitor: one expectation per falling edge, away from the active edge.
   always @(negedge clk) begin
      if (sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         case (mon_e.sel)
            SEL_RD1:  mon_act = rdata1;
            SEL_RD2:  mon_act = rdata2;
            SEL_CORR: mon_act = 32'(corr_count);
            SEL_UNC:  mon_act = 32'(uncorr_flag);
            SEL_LAST: mon_act = 32'(last_err_addr);
            default:  mon_act = 32'(scrub_busy);
         endcase
         total++;
         if (mon_act !== mon_e.exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int sel, input logic [AW-1:0] a, input logic [31:0] exp,
                      input string name);
      exp_t e;
      if (sel == SEL_RD1) raddr1 = a;
      if (sel == SEL_RD2) raddr2 = a;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      sbq.push_back(e);
      for (int i = 0; i < 8; i++) begin
         if (sbq.size() == 0) return;
         step();
      end
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s: monitor did not consume expectation (got none, expected 0x%08h)",
                  name, exp);
         sbq.delete();
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      step();
      we    = 1'b0;
   endtask

   task automatic inj(input logic [1:0] c, input logic [AW-1:0] a, input logic [XLEN-1:0] m);
      inj_en   = 1'b1;
      inj_copy = c;
      inj_addr = a;
      inj_mask = m;
      step();
      inj_en   = 1'b0;
   endtask

   // Flip copy c fully, the vote then equals the agreement of the other two.
   task automatic probe(input logic [AW-1:0] a, input logic [XLEN-1:0] v, input string nm);
      for (int c = 0; c < 3; c++) begin
         inj(2'(c), a, 32'hFFFF_FFFF);
         chk(SEL_RD1, a, v, $sformatf("%s_others_of_copy%0d", nm, c));
         inj(2'(c), a, 32'hFFFF_FFFF);
      end
   endtask

   // Two consecutive busy cycles mean the second one is REPAIR.
   task automatic wait_repair(output bit ok);
      logic prev;
      prev = 1'b0;
      ok   = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (scrub_busy === 1'b1 && prev) begin
            ok = 1'b1;
            return;
         end
         prev = scrub_busy;
      end
   endtask

   bit ok;

   initial begin
      rst_in   = 1'b0;
      we       = 1'b0;
      waddr    = '0;
      wdata    = '0;
      raddr1   = '0;
      raddr2   = '0;
      inj_en   = 1'b0;
      inj_copy = '0;
      inj_addr = '0;
      inj_mask = '0;
      scrub_en = 1'b0;
      repeat (3) step();

      // Reset state
      chk(SEL_CORR, '0, 32'd0, "rst_corr");
      chk(SEL_UNC,  '0, 32'd0, "rst_uncorr");
      chk(SEL_LAST, '0, 32'd0, "rst_last_err");
      chk(SEL_BUSY, '0, 32'd0, "rst_busy");
      chk(SEL_RD1,  5'd5, 32'd0, "rst_read_x5");
      rst_in = 1'b1;
      step();

      // Functional writes and x0
      wr(5'd5, 32'hDEAD_BEEF);
      chk(SEL_RD1, 5'd5, 32'hDEAD_BEEF, "write_x5");
      wr(5'd0, 32'hFFFF_FFFF);
      chk(SEL_RD2, 5'd0, 32'd0, "x0_reads_zero");
      wr(5'd7, 32'hA5A5_A5A0);
      wr(5'd9, 32'h0BAD_F00D);
      chk(SEL_RD1, 5'd7, 32'hA5A5_A5A0, "write_x7");
      chk(SEL_RD2, 5'd9, 32'h0BAD_F00D, "write_x9");

      // Single-copy fault masked by the vote, scrubber off
      inj(2'd1, 5'd5, 32'h0000_00FF);
      repeat (30) step();
      chk(SEL_RD1,  5'd5, 32'hDEAD_BEEF, "masked_rd1_x5");
      chk(SEL_RD2,  5'd5, 32'hDEAD_BEEF, "masked_rd2_x5");
      chk(SEL_CORR, '0, 32'd0, "noscrub_corr");
      chk(SEL_BUSY, '0, 32'd0, "noscrub_busy");

      // Scrubber repairs x5 within one sweep
      scrub_en = 1'b1;
      repeat (170) step();
      scrub_en = 1'b0;
      repeat (3) step();
      chk(SEL_CORR, '0, 32'd1, "scrub_x5_corr");
      chk(SEL_LAST, '0, 32'd5, "scrub_x5_last_err");
      chk(SEL_UNC,  '0, 32'd0, "scrub_x5_uncorr");
      chk(SEL_RD1,  5'd5, 32'hDEAD_BEEF, "scrub_x5_read");
      probe(5'd5, 32'hDEAD_BEEF, "x5");

      // Three pairwise-different copies: bitwise vote still restores x7
      inj(2'd0, 5'd7, 32'h0000_0001);
      inj(2'd2, 5'd7, 32'h0000_0002);
      chk(SEL_RD1, 5'd7, 32'hA5A5_A5A0, "x7_voted_before_scrub");
      scrub_en = 1'b1;
      repeat (170) step();
      scrub_en = 1'b0;
      repeat (3) step();
      chk(SEL_UNC,  '0, 32'd1, "x7_uncorr_flag");
      chk(SEL_CORR, '0, 32'd2, "x7_corr");
      chk(SEL_LAST, '0, 32'd7, "x7_last_err");
      probe(5'd7, 32'hA5A5_A5A0, "x7");

      // Functional write wins over the repair of x9
      inj(2'd0, 5'd9, 32'h0000_00F0);
      scrub_en = 1'b1;
      wait_repair(ok);
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL x9_repair_wait: no REPAIR seen within 400 cycles, expected one");
      end
      we       = 1'b1;
      waddr    = 5'd9;
      wdata    = 32'h1234_5678;
      scrub_en = 1'b0;
      step();
      we = 1'b0;
      repeat (2) step();
      chk(SEL_CORR, '0, 32'd2, "x9_conflict_corr");
      chk(SEL_LAST, '0, 32'd7, "x9_conflict_last_err");
      chk(SEL_RD1,  5'd9, 32'h1234_5678, "x9_conflict_read");
      probe(5'd9, 32'h1234_5678, "x9");

      // Reset asserted in the middle of a repair of x3
      inj(2'd2, 5'd3, 32'h0000_0100);
      scrub_en = 1'b1;
      wait_repair(ok);
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL x3_repair_wait: no REPAIR seen within 400 cycles, expected one");
      end
      rst_in   = 1'b0;
      scrub_en = 1'b0;
      #1;
      chk(SEL_CORR, '0, 32'd0, "midrst_corr");
      chk(SEL_LAST, '0, 32'd0, "midrst_last_err");
      chk(SEL_UNC,  '0, 32'd0, "midrst_uncorr");
      chk(SEL_BUSY, '0, 32'd0, "midrst_busy");
      chk(SEL_RD1,  5'd9, 32'd0, "midrst_read_x9");
      repeat (2) step();
      rst_in = 1'b1;
      chk(SEL_BUSY, '0, 32'd0, "post_rst_idle");
      chk(SEL_RD2,  5'd3, 32'd0, "post_rst_x3");

      // First check after reset is x1: repair completes six edges after injection
      scrub_en = 1'b1;
      inj(2'd0, 5'd1, 32'h0000_0001);
      repeat (6) step();
      scrub_en = 1'b0;
      repeat (2) step();
      chk(SEL_CORR, '0, 32'd1, "post_rst_first_corr");
      chk(SEL_LAST, '0, 32'd1, "post_rst_first_at_x1");
      chk(SEL_RD1,  5'd1, 32'd0, "post_rst_x1_read");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
